// File: rtl/counter_bus_slave.sv
// counter_bus_slave: exposes nb encoder counters as byte registers on the AVR
// multiplexed address/data bus, with a coherent snapshot taken on byte-0 reads.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   ale     address latch enable; the address is taken on its falling edge
//   rd, wr  active-low read / write strobes
//   ad_in   bus value seen at the pad
//   ad_out  read data; ad_oe enables the pad driver (high only while reading)
//   count   live counters, counter k at [k*cwidth +: cwidth]
//   clear   one-clk clear request per counter
//
// Build option: define COUNTER_BUS_ERR_EN to add a saturating protocol error
// counter readable at address 0x10 and cleared by any write to that address.
module counter_bus_slave #(
    parameter int size   = 8,
    parameter int cwidth = 16,
    parameter int nb     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ale,
    input  logic                 rd,
    input  logic                 wr,
    input  logic [size-1:0]      ad_in,
    output logic [size-1:0]      ad_out,
    output logic                 ad_oe,
    input  logic [nb*cwidth-1:0] count,
    output logic [nb-1:0]        clear
);
    typedef enum logic [1:0] {IDLE, SEL, READ, WRITE} state_t;

    state_t            state_q;
    logic [2:0]        ale_q;
    logic [1:0]        rd_q;
    logic [1:0]        wr_q;
    logic [7:0]        addr_q;
    logic [cwidth-1:0] shadow_q [nb];
    logic [size-1:0]   ad_out_q;
    logic              ad_oe_q;
    logic [nb-1:0]     clear_q;

    logic              ale_fall;
    logic              rd_s;
    logic              wr_s;
    logic [7:0]        a;
    logic              new_cnt;
    logic              new_err;
    logic              new_sel;
    logic              cur_cnt;
    logic [cwidth-1:0] live;
    logic [cwidth-1:0] shad;
    logic [cwidth-1:0] rd_word;
    logic [size-1:0]   new_byte;

    // ale_q[1] is the synchronised level, ale_q[2] its previous value
    assign ale_fall = ale_q[2] & ~ale_q[1];
    assign rd_s     = rd_q[1];
    assign wr_s     = wr_q[1];
    assign a        = ad_in[7:0];
    assign new_cnt  = a[7:4] == 4'd0 && int'(a[3:2]) < nb;
    assign cur_cnt  = addr_q[7:4] == 4'd0 && int'(addr_q[3:2]) < nb;
    assign new_sel  = new_cnt | new_err;

    always_comb begin
        live = '0;
        shad = '0;
        for (int i = 0; i < nb; i++)
            if (int'(a[3:2]) == i) begin
                live = count[i*cwidth +: cwidth];
                shad = shadow_q[i];
            end
    end

    // Byte 0 comes from the value being captured; bytes past the counter width shift out to zero
    assign rd_word = (a[1:0] == 2'd0 ? live : shad) >> (int'(a[1:0]) * size);

`ifdef COUNTER_BUS_ERR_EN
    logic [7:0] err_q;
    logic       cur_err;

    assign new_err  = a == 8'h10;
    assign cur_err  = addr_q == 8'h10;
    assign new_byte = new_err ? size'(err_q) : new_cnt ? rd_word[size-1:0] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= '0;
        else if (!ale_fall && state_q == WRITE && wr_s && cur_err)
            err_q <= '0;
        else if (err_q != 8'hFF && ((ale_fall && (state_q == READ || state_q == WRITE)) ||
                 (!ale_fall && state_q == SEL && !rd_s && !wr_s)))
            err_q <= err_q + 8'd1;
    end
`else
    assign new_err  = 1'b0;
    assign new_byte = new_cnt ? rd_word[size-1:0] : '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ale_q    <= '1;
            rd_q     <= '1;
            wr_q     <= '1;
            addr_q   <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            clear_q  <= '0;
            for (int i = 0; i < nb; i++)
                shadow_q[i] <= '0;
        end else begin
            ale_q   <= {ale_q[1:0], ale};
            rd_q    <= {rd_q[0], rd};
            wr_q    <= {wr_q[0], wr};
            clear_q <= '0;
            // An ALE fall aborts whatever access is in progress
            if (ale_fall) begin
                addr_q   <= a;
                ad_out_q <= new_byte;
                ad_oe_q  <= 1'b0;
                state_q  <= new_sel ? SEL : IDLE;
                for (int i = 0; i < nb; i++)
                    if (new_cnt && a[1:0] == 2'd0 && int'(a[3:2]) == i)
                        shadow_q[i] <= live;
            end else begin
                case (state_q)
                    SEL: begin
                        state_q <= !rd_s ? READ : !wr_s ? WRITE : SEL;
                        ad_oe_q <= !rd_s;
                    end
                    READ: if (rd_s) begin
                        state_q <= IDLE;
                        ad_oe_q <= 1'b0;
                    end
                    WRITE: if (wr_s) begin
                        state_q <= IDLE;
                        for (int i = 0; i < nb; i++)
                            clear_q[i] <= cur_cnt && addr_q[1:0] == 2'd0 && ad_in[0] &&
                                          int'(addr_q[3:2]) == i;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ad_out = ad_out_q;
    assign ad_oe  = ad_oe_q;
    assign clear  = clear_q;
endmodule

// File: tb/tb_counter_bus_slave.sv
// tb_counter_bus_slave: directed vector bench for counter_bus_slave (nb=3, cwidth=16).
module tb_counter_bus_slave;
    localparam int SIZE = 8;
    localparam int CW   = 16;
    localparam int NB   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ale = 1'b0;
    logic              rd  = 1'b1;
    logic              wr  = 1'b1;
    logic [SIZE-1:0]   ad_in = '0;
    logic [SIZE-1:0]   ad_out;
    logic              ad_oe;
    logic [NB*CW-1:0]  count = '0;
    logic [NB-1:0]     clear;

    int n_vec = 0;
    int n_bad = 0;

    counter_bus_slave #(.size(SIZE), .cwidth(CW), .nb(NB)) dut (
        .clk(clk), .rst(rst), .ale(ale), .rd(rd), .wr(wr),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .count(count), .clear(clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [47:0] cnt;
        bit         oe;
        logic [7:0] data;
        logic [2:0] clr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit w, input logic [7:0] ad, input logic [7:0] wd,
                       input logic [47:0] c, input bit oe, input logic [7:0] d,
                       input logic [2:0] cl);
        vec_t v;
        v.is_wr = w; v.addr = ad; v.wdata = wd; v.cnt = c; v.oe = oe; v.data = d; v.clr = cl;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic latch(input logic [7:0] ad);
        ad_in = ad;
        ale = 1'b1;
        cyc(2);
        ale = 1'b0;
        cyc(5);
    endtask

    task automatic do_read(input logic [7:0] ad, output logic oe, output logic [7:0] d,
                           output logic oe_late, output logic oe_seen);
        latch(ad);
        oe_seen = 1'b0;
        oe = 1'b0;
        d = '0;
        rd = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            oe_seen |= ad_oe;
            if (i == 3) begin
                oe = ad_oe;
                d = ad_out;
            end
        end
        rd = 1'b1;
        cyc(3);
        oe_late = ad_oe;
    endtask

    task automatic do_write(input logic [7:0] ad, input logic [7:0] wd, output int nz,
                            output int at, output logic [2:0] val);
        latch(ad);
        ad_in = wd;
        wr = 1'b0;
        cyc(4);
        wr = 1'b1;
        nz = 0; at = 0; val = '0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            if (clear != '0) begin
                nz++;
                val |= clear;
                if (at == 0) at = i;
            end
        end
    endtask

    logic       r_oe, r_late, r_seen;
    logic [7:0] r_d;
    int         w_nz, w_at;
    logic [2:0] w_val;

    initial begin
        add(0, 8'h00, 8'h00, 48'h0000_0000_12AB, 1, 8'hAB, 3'b000);
        add(0, 8'h01, 8'h00, 48'h0000_0000_12AB, 1, 8'h12, 3'b000);
        add(0, 8'h00, 8'h00, 48'h0000_0000_12FF, 1, 8'hFF, 3'b000);
        add(0, 8'h01, 8'h00, 48'h0000_0000_1300, 1, 8'h12, 3'b000);
        add(0, 8'h00, 8'h00, 48'h0000_0000_1300, 1, 8'h00, 3'b000);
        add(0, 8'h01, 8'h00, 48'h0000_0000_1300, 1, 8'h13, 3'b000);
        add(0, 8'h02, 8'h00, 48'h0000_0000_1300, 1, 8'h00, 3'b000);
        add(0, 8'h03, 8'h00, 48'h0000_0000_1300, 1, 8'h00, 3'b000);
        add(0, 8'h04, 8'h00, 48'hC3D4_A1B2_1300, 1, 8'hB2, 3'b000);
        add(0, 8'h05, 8'h00, 48'hC3D4_A1B2_1300, 1, 8'hA1, 3'b000);
        add(0, 8'h08, 8'h00, 48'hC3D4_A1B2_1300, 1, 8'hD4, 3'b000);
        add(0, 8'h09, 8'h00, 48'hC3D4_A1B2_1300, 1, 8'hC3, 3'b000);
        add(0, 8'h01, 8'h00, 48'hFFFF_FFFF_FFFF, 1, 8'h13, 3'b000);
        add(0, 8'h05, 8'h00, 48'hFFFF_FFFF_FFFF, 1, 8'hA1, 3'b000);
        add(0, 8'h0C, 8'h00, 48'hFFFF_FFFF_FFFF, 0, 8'h00, 3'b000);
        add(0, 8'h0D, 8'h00, 48'hFFFF_FFFF_FFFF, 0, 8'h00, 3'b000);
        add(0, 8'h20, 8'h00, 48'hFFFF_FFFF_FFFF, 0, 8'h00, 3'b000);
        add(0, 8'h80, 8'h00, 48'hFFFF_FFFF_FFFF, 0, 8'h00, 3'b000);
        add(1, 8'h08, 8'h01, 48'h0, 0, 8'h00, 3'b100);
        add(1, 8'h08, 8'h00, 48'h0, 0, 8'h00, 3'b000);
        add(1, 8'h09, 8'h01, 48'h0, 0, 8'h00, 3'b000);
        add(1, 8'h00, 8'h01, 48'h0, 0, 8'h00, 3'b001);
        add(1, 8'h04, 8'hFF, 48'h0, 0, 8'h00, 3'b010);
        add(1, 8'h0C, 8'h01, 48'h0, 0, 8'h00, 3'b000);
        add(1, 8'h20, 8'h01, 48'h0, 0, 8'h00, 3'b000);
        add(1, 8'h01, 8'h01, 48'h0, 0, 8'h00, 3'b000);

        // reset state
        cyc(3);
        chk("reset ad_oe", ad_oe, 0);
        chk("reset ad_out", ad_out, 0);
        chk("reset clear", clear, 0);
        rst = 1'b1;
        cyc(2);

        // first read: drive 3 clk after RD fall, release 3 clk after RD rise
        count = 48'h0000_0000_12AB;
        latch(8'h00);
        rd = 1'b0;
        cyc(2);
        chk("rd fall +2 oe", ad_oe, 0);
        cyc(1);
        chk("rd fall +3 oe", ad_oe, 1);
        chk("rd fall +3 data", ad_out, 8'hAB);
        rd = 1'b1;
        cyc(2);
        chk("rd rise +2 oe", ad_oe, 1);
        cyc(1);
        chk("rd rise +3 oe", ad_oe, 0);

        foreach (vq[i]) begin
            count = vq[i].cnt;
            if (!vq[i].is_wr) begin
                do_read(vq[i].addr, r_oe, r_d, r_late, r_seen);
                if (vq[i].oe) begin
                    chk($sformatf("vec%0d rd %02h oe", i, vq[i].addr), r_oe, 1);
                    chk($sformatf("vec%0d rd %02h data", i, vq[i].addr), r_d, vq[i].data);
                    chk($sformatf("vec%0d rd %02h release", i, vq[i].addr), r_late, 0);
                end else
                    chk($sformatf("vec%0d rd %02h undriven", i, vq[i].addr), r_seen, 0);
            end else begin
                do_write(vq[i].addr, vq[i].wdata, w_nz, w_at, w_val);
                if (vq[i].clr != '0) begin
                    chk($sformatf("vec%0d wr %02h clear", i, vq[i].addr), w_val, vq[i].clr);
                    chk($sformatf("vec%0d wr %02h pulse len", i, vq[i].addr), w_nz, 1);
                    chk($sformatf("vec%0d wr %02h pulse time", i, vq[i].addr), w_at, 3);
                end else
                    chk($sformatf("vec%0d wr %02h no pulse", i, vq[i].addr), w_nz, 0);
            end
        end

        // ALE fall during READ aborts, then the new address is decoded
        count = 48'h0000_0000_5A6B;
        latch(8'h00);
        rd = 1'b0;
        cyc(4);
        chk("abort pre oe", ad_oe, 1);
        chk("abort pre data", ad_out, 8'h6B);
        ad_in = 8'h01;
        ale = 1'b1;
        cyc(2);
        ale = 1'b0;
        cyc(3);
        chk("abort oe drop", ad_oe, 0);
        cyc(1);
        chk("abort reselect oe", ad_oe, 1);
        chk("abort new addr data", ad_out, 8'h5A);
        rd = 1'b1;
        cyc(4);
        chk("abort release", ad_oe, 0);

        // RD and WR together: read wins, no clear
        latch(8'h08);
        rd = 1'b0;
        wr = 1'b0;
        cyc(4);
        chk("rd+wr oe", ad_oe, 1);
        w_nz = 0;
        rd = 1'b1;
        wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (clear != '0) w_nz++;
        end
        chk("rd+wr no clear", w_nz, 0);

        // asynchronous reset mid-read
        count = 48'h0000_0000_7788;
        latch(8'h00);
        rd = 1'b0;
        cyc(4);
        chk("mid-read oe", ad_oe, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async reset oe", ad_oe, 0);
        chk("async reset data", ad_out, 0);
        rd = 1'b1;
        #3;
        rst = 1'b1;
        cyc(2);
        do_read(8'h01, r_oe, r_d, r_late, r_seen);
        chk("post-reset shadow0 oe", r_oe, 1);
        chk("post-reset shadow0 byte1", r_d, 8'h00);
        do_read(8'h05, r_oe, r_d, r_late, r_seen);
        chk("post-reset shadow1 byte1", r_d, 8'h00);

`ifdef COUNTER_BUS_ERR_EN
        for (int i = 0; i < 3; i++) begin
            latch(8'h00);
            rd = 1'b0;
            wr = 1'b0;
            cyc(4);
            rd = 1'b1;
            wr = 1'b1;
            cyc(4);
        end
        do_read(8'h10, r_oe, r_d, r_late, r_seen);
        chk("err oe", r_oe, 1);
        chk("err after 3", r_d, 8'h03);
        do_write(8'h10, 8'h5A, w_nz, w_at, w_val);
        chk("err write no clear", w_nz, 0);
        do_read(8'h10, r_oe, r_d, r_late, r_seen);
        chk("err cleared", r_d, 8'h00);
        latch(8'h00);
        rd = 1'b0;
        cyc(4);
        ad_in = 8'h00;
        for (int i = 0; i < 300; i++) begin
            ale = 1'b1;
            cyc(2);
            ale = 1'b0;
            cyc(4);
        end
        rd = 1'b1;
        cyc(4);
        do_read(8'h10, r_oe, r_d, r_late, r_seen);
        chk("err saturated", r_d, 8'hFF);
`else
        do_read(8'h10, r_oe, r_d, r_late, r_seen);
        chk("addr 10 undriven", r_seen, 0);
        do_write(8'h10, 8'h01, w_nz, w_at, w_val);
        chk("addr 10 no clear", w_nz, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
